i2s_rx_axis: RTL

I2S serial-audio receiver that converts an external I2S stream (BCLK/LRCLK/SDATA) into packed stereo AXI4-Stream words for the stereo delay stage directly downstream. It oversamples the asynchronous I2S pins in the `aclk` domain, deserialises left and right slots, and packs each pair as `{Right, Left}`. Pairs are buffered in a small FIFO with a sticky overflow flag, and `tlast` is asserted on a fixed frame period.

---
 rtl/audio_pkg.sv | 29 ++
 rtl/axis_sync_fifo.sv | 67 ++++++
 rtl/i2s_rx_axis.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared audio definitions: default sample width, stereo packing order and the
// I2S receiver FSM state encoding.
package audio_pkg;

  localparam int unsigned AUDIO_WIDTH_DEF = 16;

  typedef logic [AUDIO_WIDTH_DEF-1:0]   sample_t;
  typedef logic [2*AUDIO_WIDTH_DEF-1:0] stereo_t;

  typedef enum logic [1:0] {
    SYNC_WAIT,
    LEFT,
    RIGHT
  } rx_state_e;

  // Right channel lives in the upper half of a stereo word.
  function automatic stereo_t pack_stereo(input sample_t right, input sample_t left);
    return {right, left};
  endfunction

  function automatic sample_t unpack_left(input stereo_t word);
    return word[AUDIO_WIDTH_DEF-1:0];
  endfunction

  function automatic sample_t unpack_right(input stereo_t word);
    return word[2*AUDIO_WIDTH_DEF-1:AUDIO_WIDTH_DEF];
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock shift-register FIFO; the head entry is always register 0 so the
// output is glitch-free and stable while stalled. Push while full succeeds if a pop
// happens in the same cycle.
module axis_sync_fifo #(
  parameter int unsigned Width = 33,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CntW-1:0]  wr_idx;
  logic             do_pop, do_push;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[0];
  assign wr_idx  = do_pop ? (cnt_q - CntW'(1)) : cnt_q;

  always_comb begin
    for (int i = 0; i < int'(Depth); i++) begin
      mem_d[i] = mem_q[i];
    end
    if (do_pop) begin
      for (int i = 0; i < int'(Depth) - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
    end
    // Write after the shift so a simultaneous push lands behind the survivors.
    if (do_push) begin
      for (int i = 0; i < int'(Depth); i++) begin
        if (wr_idx == CntW'(i)) begin
          mem_d[i] = data_i;
        end
      end
    end
    cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/i2s_rx_axis.sv
// Philips-format I2S receiver: oversamples the I2S pins on aclk, deserialises left and
// right slots and streams packed {Right, Left} pairs through a small FIFO with tlast framing.
module i2s_rx_axis
  import audio_pkg::*;
#(
  parameter int unsigned AUDIO_WIDTH  = AUDIO_WIDTH_DEF,
  parameter int unsigned TLAST_PERIOD = 256,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     enable,
  input  logic                     clear_overflow,
  input  logic                     i2s_bclk,
  input  logic                     i2s_lrclk,
  input  logic                     i2s_sdata,
  output logic [2*AUDIO_WIDTH-1:0] m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     overflow
);

  localparam int unsigned BitCntW   = $clog2(AUDIO_WIDTH + 1);
  localparam int unsigned FrameCntW = (TLAST_PERIOD > 1) ? $clog2(TLAST_PERIOD) : 1;
  localparam int unsigned EntryW    = 2 * AUDIO_WIDTH + 1;

  // Pin synchronisers plus one extra stage so LRCLK/SDATA line up with bclk_rise_q.
  logic [2:0] bclk_q;
  logic [1:0] lrclk_sync_q, sdata_sync_q;
  logic       bclk_rise_q, lrclk_smp_q, sdata_smp_q;
  logic       lr_prev_q;
  logic       lr_change;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bclk_q       <= '0;
      lrclk_sync_q <= '0;
      sdata_sync_q <= '0;
      bclk_rise_q  <= 1'b0;
      lrclk_smp_q  <= 1'b0;
      sdata_smp_q  <= 1'b0;
      lr_prev_q    <= 1'b0;
    end else begin
      bclk_q       <= {bclk_q[1:0], i2s_bclk};
      lrclk_sync_q <= {lrclk_sync_q[0], i2s_lrclk};
      sdata_sync_q <= {sdata_sync_q[0], i2s_sdata};
      bclk_rise_q  <= bclk_q[1] & ~bclk_q[2];
      lrclk_smp_q  <= lrclk_sync_q[1];
      sdata_smp_q  <= sdata_sync_q[1];
      if (bclk_rise_q) begin
        lr_prev_q <= lrclk_smp_q;
      end
    end
  end

  assign lr_change = bclk_rise_q && (lrclk_smp_q != lr_prev_q);

  // Current channel word with this edge's bit placed at its MSB-first position.
  logic [AUDIO_WIDTH-1:0] word_q, word_ins;
  logic [BitCntW-1:0]     bit_cnt_q;

  always_comb begin
    word_ins = word_q;
    for (int i = 0; i < int'(AUDIO_WIDTH); i++) begin
      if (bit_cnt_q == BitCntW'(AUDIO_WIDTH - 1 - i)) begin
        word_ins[i] = sdata_smp_q;
      end
    end
  end

  rx_state_e                state_q;
  logic [AUDIO_WIDTH-1:0]   hold_l_q;
  logic                     push_q;
  logic [2*AUDIO_WIDTH-1:0] push_data_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= SYNC_WAIT;
      word_q      <= '0;
      bit_cnt_q   <= '0;
      hold_l_q    <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      push_q <= 1'b0;
      if (!enable) begin
        state_q <= SYNC_WAIT;
      end else if (bclk_rise_q) begin
        if (lr_change) begin
          // The bit on a change edge is the old slot's last bit, hence word_ins.
          word_q    <= '0;
          bit_cnt_q <= '0;
          unique case (state_q)
            SYNC_WAIT: begin
              if (!lrclk_smp_q) begin
                state_q <= LEFT;
              end
            end
            LEFT: begin
              if (lrclk_smp_q) begin
                hold_l_q <= word_ins;
                state_q  <= RIGHT;
              end
            end
            RIGHT: begin
              if (!lrclk_smp_q) begin
                push_q      <= 1'b1;
                push_data_q <= {word_ins, hold_l_q};
                state_q     <= LEFT;
              end
            end
            default: state_q <= SYNC_WAIT;
          endcase
        end else begin
          word_q <= word_ins;
          if (bit_cnt_q != BitCntW'(AUDIO_WIDTH)) begin
            bit_cnt_q <= bit_cnt_q + BitCntW'(1);
          end
        end
      end
    end
  end

  logic                 fifo_full, fifo_empty;
  logic                 pop, push_ok, push_last;
  logic [EntryW-1:0]    fifo_head;
  logic [FrameCntW-1:0] frame_cnt_q;
  logic                 overflow_q;

  assign pop       = m_axis_tready && !fifo_empty;
  assign push_ok   = push_q && (!fifo_full || pop);
  assign push_last = (frame_cnt_q == FrameCntW'(TLAST_PERIOD - 1));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (!enable) begin
        frame_cnt_q <= '0;
      end else if (push_ok) begin
        frame_cnt_q <= push_last ? '0 : frame_cnt_q + FrameCntW'(1);
      end
      // A new drop outranks a simultaneous clear.
      if (push_q && !push_ok) begin
        overflow_q <= 1'b1;
      end else if (clear_overflow) begin
        overflow_q <= 1'b0;
      end
    end
  end

  axis_sync_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (aclk),
    .rst_ni  (aresetn),
    .push_i  (push_q),
    .data_i  ({push_last, push_data_q}),
    .pop_i   (m_axis_tready),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {m_axis_tlast, m_axis_tdata} = fifo_head;
  assign m_axis_tvalid = !fifo_empty;
  assign overflow      = overflow_q;

endmodule
